// File: rtl/rf_arb_pkg.sv
// Shared constants and the long-latency result entry type for the register-file write-port arbiter.
package rf_arb_pkg;

    localparam int DW           = 32;
    localparam int AW           = 5;
    localparam int NREG         = 1 << AW;
    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } rf_entry_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Small synchronous FIFO buffering long-latency results; head is visible combinationally.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      push_i,
    input  rf_entry_t push_data_i,
    input  logic      pop_i,
    output rf_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rf_entry_t     mem_q [DEPTH];
    rf_entry_t     mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_push) begin
            mem_d[wptr_q] = push_data_i;
            wptr_d        = wptr_q + PW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the register-file write port between WB and buffered mul/div results, with a busy scoreboard.
// Optional starvation guard enabled by defining RF_ARB_STARVE_GUARD_EN.
module rf_wport_arbiter
    import rf_arb_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            wb_we_i,
    input  logic [AW-1:0]   wb_wr_i,
    input  logic [DW-1:0]   wb_wd_i,
    input  logic            lu_issue_i,
    input  logic [AW-1:0]   lu_issue_rd_i,
    input  logic            lu_valid_i,
    input  logic [AW-1:0]   lu_rd_i,
    input  logic [DW-1:0]   lu_wd_i,
    output logic            lu_ready_o,
    input  logic [AW-1:0]   rR1_i,
    input  logic [AW-1:0]   rR2_i,
    output logic            hazard_o,
    output logic            rf_we_o,
    output logic [AW-1:0]   rf_wr_o,
    output logic [DW-1:0]   rf_wd_o,
    output logic            wb_stall_o,
    output logic [NREG-1:0] busy_o
);

    logic            armed_q, armed_d;
    logic [NREG-1:0] busy_q, busy_d;
    rf_entry_t       head, push_ent;
    logic            full, empty, push, pop, wb_req, force_lu;

    assign push_ent   = '{rd: lu_rd_i, data: lu_wd_i};
    assign lu_ready_o = ~full;
    assign push       = lu_valid_i & ~full;
    assign wb_req     = wb_we_i & (wb_wr_i != '0);
    assign busy_o     = busy_q;
    assign hazard_o   = ((rR1_i != '0) & busy_q[rR1_i]) | ((rR2_i != '0) & busy_q[rR2_i]);
    assign wb_stall_o = force_lu;

    rf_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (push),
        .push_data_i (push_ent),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_q, starve_d;

    assign force_lu = armed_q & ~empty & (starve_q == SW'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (pop) begin
            starve_d = '0;
        end else if (armed_q && !empty) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_lu = 1'b0;
`endif

    // Port stays idle until the first edge after reset; an x0 head is popped without a write.
    always_comb begin
        pop     = 1'b0;
        rf_we_o = 1'b0;
        rf_wr_o = '0;
        rf_wd_o = '0;
        if (armed_q) begin
            if (wb_req && !force_lu) begin
                rf_we_o = 1'b1;
                rf_wr_o = wb_wr_i;
                rf_wd_o = wb_wd_i;
            end else if (!empty) begin
                pop = 1'b1;
                if (head.rd != '0) begin
                    rf_we_o = 1'b1;
                    rf_wr_o = head.rd;
                    rf_wd_o = head.data;
                end
            end
        end
    end

    // Clear first so a same-cycle issue to the retiring register keeps it busy.
    always_comb begin
        busy_d  = busy_q;
        armed_d = 1'b1;
        if (pop && rf_we_o) begin
            busy_d[head.rd] = 1'b0;
        end
        if (lu_issue_i && (lu_issue_rd_i != '0)) begin
            busy_d[lu_issue_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            armed_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            armed_q <= armed_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_rf_wport_arbiter;
    import rf_arb_pkg::*;

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_n_i = 1'b1;
    logic            wb_we_i, lu_issue_i, lu_valid_i;
    logic [AW-1:0]   wb_wr_i, lu_issue_rd_i, lu_rd_i, rR1_i, rR2_i;
    logic [DW-1:0]   wb_wd_i, lu_wd_i;
    logic            lu_ready_o, hazard_o, rf_we_o, wb_stall_o;
    logic [AW-1:0]   rf_wr_o;
    logic [DW-1:0]   rf_wd_o;
    logic [NREG-1:0] busy_o;

    int vec_cnt = 0;
    int miss_cnt = 0;

    always #5 clk_i = ~clk_i;

    rf_wport_arbiter dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .wb_we_i(wb_we_i), .wb_wr_i(wb_wr_i), .wb_wd_i(wb_wd_i),
        .lu_issue_i(lu_issue_i), .lu_issue_rd_i(lu_issue_rd_i),
        .lu_valid_i(lu_valid_i), .lu_rd_i(lu_rd_i), .lu_wd_i(lu_wd_i),
        .lu_ready_o(lu_ready_o), .rR1_i(rR1_i), .rR2_i(rR2_i), .hazard_o(hazard_o),
        .rf_we_o(rf_we_o), .rf_wr_o(rf_wr_o), .rf_wd_o(rf_wd_o),
        .wb_stall_o(wb_stall_o), .busy_o(busy_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle();
        wb_we_i = 1'b0; wb_wr_i = '0; wb_wd_i = '0;
        lu_issue_i = 1'b0; lu_issue_rd_i = '0;
        lu_valid_i = 1'b0; lu_rd_i = '0; lu_wd_i = '0;
        rR1_i = '0; rR2_i = '0;
    endtask

    task automatic test_reset();
        idle();
        #1 rst_n_i = 1'b0;
        #1;
        vec_cnt++; if (busy_o !== '0) begin miss_cnt++; $display("FAIL rst_busy got=%h want=0", busy_o); end
        vec_cnt++; if (lu_ready_o !== 1'b1) begin miss_cnt++; $display("FAIL rst_ready got=%b want=1", lu_ready_o); end
        vec_cnt++; if (rf_we_o !== 1'b0) begin miss_cnt++; $display("FAIL rst_we got=%b want=0", rf_we_o); end
        vec_cnt++; if ({hazard_o, wb_stall_o} !== 2'b00) begin miss_cnt++; $display("FAIL rst_haz_stall got=%b%b want=00", hazard_o, wb_stall_o); end
        tick(); tick();
        rst_n_i = 1'b1;
        wb_we_i = 1'b1; wb_wr_i = 5'd5; wb_wd_i = 32'h1234_5678;
        #1;
        vec_cnt++; if (rf_we_o !== 1'b0) begin miss_cnt++; $display("FAIL unarmed_we got=%b want=0", rf_we_o); end
        tick();
        vec_cnt++; if ({rf_we_o, rf_wr_o, rf_wd_o} !== {1'b1, 5'd5, 32'h1234_5678})
            begin miss_cnt++; $display("FAIL armed_wb got=%b/%0d/%h want=1/5/12345678", rf_we_o, rf_wr_o, rf_wd_o); end
        idle(); tick();
    endtask

    task automatic test_issue();
        lu_issue_i = 1'b1; lu_issue_rd_i = 5'd7; #1;
        vec_cnt++; if (busy_o[7] !== 1'b0) begin miss_cnt++; $display("FAIL issue_busy_early got=%b want=0", busy_o[7]); end
        tick();
        lu_issue_i = 1'b0; lu_valid_i = 1'b1; lu_rd_i = 5'd7; lu_wd_i = 32'hDEAD_BEEF; rR1_i = 5'd7; #1;
        vec_cnt++; if ({busy_o[7], hazard_o, rf_we_o, lu_ready_o} !== 4'b1101)
            begin miss_cnt++; $display("FAIL issue_pending got=%b%b%b%b want=1101", busy_o[7], hazard_o, rf_we_o, lu_ready_o); end
        tick();
        lu_valid_i = 1'b0; rR1_i = '0; rR2_i = 5'd7; #1;
        vec_cnt++; if ({rf_we_o, rf_wr_o, rf_wd_o, hazard_o} !== {1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1})
            begin miss_cnt++; $display("FAIL issue_write got=%b/%0d/%h/%b want=1/7/deadbeef/1", rf_we_o, rf_wr_o, rf_wd_o, hazard_o); end
        tick();
        rR1_i = 5'd7; #1;
        vec_cnt++; if ({busy_o[7], hazard_o, rf_we_o} !== 3'b000)
            begin miss_cnt++; $display("FAIL issue_cleared got=%b%b%b want=000", busy_o[7], hazard_o, rf_we_o); end
        idle(); tick();
    endtask

    task automatic test_backpressure();
        wb_we_i = 1'b1; wb_wr_i = 5'd10; wb_wd_i = 32'hAAAA_0010;
        lu_valid_i = 1'b1; lu_rd_i = 5'd3; lu_wd_i = 32'h0000_0333; tick();
        lu_rd_i = 5'd4; lu_wd_i = 32'h0000_0444; tick();
        lu_rd_i = 5'd5; lu_wd_i = 32'h0000_0555; #1;
        vec_cnt++; if ({lu_ready_o, rf_wr_o, wb_stall_o} !== {1'b0, 5'd10, 1'b0})
            begin miss_cnt++; $display("FAIL bp_full got=%b/%0d/%b want=0/10/0", lu_ready_o, rf_wr_o, wb_stall_o); end
        tick();
        wb_we_i = 1'b0; #1;
        vec_cnt++; if ({lu_ready_o, rf_we_o, rf_wr_o, rf_wd_o} !== {1'b0, 1'b1, 5'd3, 32'h333})
            begin miss_cnt++; $display("FAIL bp_drain3 got=%b/%b/%0d/%h want=0/1/3/333", lu_ready_o, rf_we_o, rf_wr_o, rf_wd_o); end
        tick(); #1;
        vec_cnt++; if ({lu_ready_o, rf_we_o, rf_wr_o, rf_wd_o} !== {1'b1, 1'b1, 5'd4, 32'h444})
            begin miss_cnt++; $display("FAIL bp_drain4 got=%b/%b/%0d/%h want=1/1/4/444", lu_ready_o, rf_we_o, rf_wr_o, rf_wd_o); end
        tick();
        lu_valid_i = 1'b0; #1;
        vec_cnt++; if ({rf_we_o, rf_wr_o, rf_wd_o} !== {1'b1, 5'd5, 32'h555})
            begin miss_cnt++; $display("FAIL bp_drain5 got=%b/%0d/%h want=1/5/555", rf_we_o, rf_wr_o, rf_wd_o); end
        tick(); #1;
        vec_cnt++; if (rf_we_o !== 1'b0) begin miss_cnt++; $display("FAIL bp_empty got=%b want=0", rf_we_o); end
        idle(); tick();
    endtask

    task automatic test_set_wins();
        lu_issue_i = 1'b1; lu_issue_rd_i = 5'd9; tick();
        lu_issue_i = 1'b0; lu_valid_i = 1'b1; lu_rd_i = 5'd9; lu_wd_i = 32'h99; tick();
        lu_valid_i = 1'b0; lu_issue_i = 1'b1; #1;
        vec_cnt++; if ({rf_we_o, rf_wr_o} !== {1'b1, 5'd9}) begin miss_cnt++; $display("FAIL sw_pop got=%b/%0d want=1/9", rf_we_o, rf_wr_o); end
        tick();
        idle(); #1;
        vec_cnt++; if (busy_o[9] !== 1'b1) begin miss_cnt++; $display("FAIL sw_busy9 got=%b want=1", busy_o[9]); end
        tick();
    endtask

    task automatic test_starve();
        wb_we_i = 1'b1; wb_wr_i = 5'd11; wb_wd_i = 32'hB;
        lu_valid_i = 1'b1; lu_rd_i = 5'd2; lu_wd_i = 32'h22; tick();
        lu_valid_i = 1'b0;
`ifdef RF_ARB_STARVE_GUARD_EN
        for (int i = 1; i <= 4; i++) begin
            #1;
            vec_cnt++; if ({wb_stall_o, rf_wr_o} !== {1'b0, 5'd11})
                begin miss_cnt++; $display("FAIL starve_wait%0d got=%b/%0d want=0/11", i, wb_stall_o, rf_wr_o); end
            tick();
        end
        #1;
        vec_cnt++; if ({wb_stall_o, rf_we_o, rf_wr_o, rf_wd_o} !== {1'b1, 1'b1, 5'd2, 32'h22})
            begin miss_cnt++; $display("FAIL starve_force got=%b/%b/%0d/%h want=1/1/2/22", wb_stall_o, rf_we_o, rf_wr_o, rf_wd_o); end
        tick();
`else
        for (int i = 1; i <= 5; i++) begin
            #1;
            vec_cnt++; if ({wb_stall_o, rf_wr_o} !== {1'b0, 5'd11})
                begin miss_cnt++; $display("FAIL nostarve_wait%0d got=%b/%0d want=0/11", i, wb_stall_o, rf_wr_o); end
            tick();
        end
        wb_we_i = 1'b0; #1;
        vec_cnt++; if ({wb_stall_o, rf_we_o, rf_wr_o, rf_wd_o} !== {1'b0, 1'b1, 5'd2, 32'h22})
            begin miss_cnt++; $display("FAIL nostarve_write got=%b/%b/%0d/%h want=0/1/2/22", wb_stall_o, rf_we_o, rf_wr_o, rf_wd_o); end
        tick();
`endif
        idle(); tick();
    endtask

    task automatic test_reset_mid();
        wb_we_i = 1'b1; wb_wr_i = 5'd10;
        lu_issue_i = 1'b1; lu_issue_rd_i = 5'd12; tick();
        lu_issue_rd_i = 5'd13; lu_valid_i = 1'b1; lu_rd_i = 5'd12; tick();
        lu_issue_i = 1'b0; lu_rd_i = 5'd13; tick();
        lu_valid_i = 1'b0; #1;
        vec_cnt++; if ({lu_ready_o, busy_o[13:12]} !== 3'b011)
            begin miss_cnt++; $display("FAIL rm_queued got=%b/%b want=0/11", lu_ready_o, busy_o[13:12]); end
        idle(); rst_n_i = 1'b0; #1;
        vec_cnt++; if ({busy_o, lu_ready_o, rf_we_o, wb_stall_o} !== {32'h0, 1'b1, 1'b0, 1'b0})
            begin miss_cnt++; $display("FAIL rm_reset got=%h/%b/%b/%b want=0/1/0/0", busy_o, lu_ready_o, rf_we_o, wb_stall_o); end
        tick();
        rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++; if (rf_we_o !== 1'b0) begin miss_cnt++; $display("FAIL rm_nowrite%0d got=%b want=0", i, rf_we_o); end
            tick();
        end
    endtask

    task automatic test_random(input int n);
        logic [AW-1:0] q_rd[$];
        logic [DW-1:0] q_wd[$];
        logic [NREG-1:0] m_busy;
        bit m_armed, full, forced, nonempty, e_pop, e_we, e_haz;
        int m_starve;
        logic [AW-1:0] e_wr;
        logic [DW-1:0] e_wd;
        idle();
        rst_n_i = 1'b0; #1; rst_n_i = 1'b1;
        m_busy = '0; m_armed = 1'b0; m_starve = 0;
        for (int c = 0; c < n; c++) begin
            wb_we_i = ($urandom_range(0, 9) < (((c / 100) % 2 == 1) ? 9 : 5));
            wb_wr_i = AW'($urandom_range(0, 31)); wb_wd_i = $urandom;
            lu_issue_i = ($urandom_range(0, 2) == 0); lu_issue_rd_i = AW'($urandom_range(0, 31));
            lu_valid_i = ($urandom_range(0, 1) == 1); lu_rd_i = AW'($urandom_range(0, 31)); lu_wd_i = $urandom;
            rR1_i = AW'($urandom_range(0, 31)); rR2_i = AW'($urandom_range(0, 31));
            #1;
            nonempty = (q_rd.size() > 0);
            full = (q_rd.size() == FIFO_DEPTH);
            forced = STARVE_EN && m_armed && nonempty && (m_starve == STARVE_LIMIT);
            e_pop = 1'b0; e_we = 1'b0; e_wr = '0; e_wd = '0;
            if (m_armed) begin
                if (wb_we_i && wb_wr_i != 0 && !forced) begin
                    e_we = 1'b1; e_wr = wb_wr_i; e_wd = wb_wd_i;
                end else if (nonempty) begin
                    e_pop = 1'b1; e_we = (q_rd[0] != 0); e_wr = q_rd[0]; e_wd = q_wd[0];
                end
            end
            e_haz = (rR1_i != 0 && m_busy[rR1_i]) || (rR2_i != 0 && m_busy[rR2_i]);
            vec_cnt++;
            if (rf_we_o !== e_we || (e_we && (rf_wr_o !== e_wr || rf_wd_o !== e_wd)) ||
                lu_ready_o !== !full || hazard_o !== e_haz || busy_o !== m_busy || wb_stall_o !== forced)
                begin miss_cnt++;
                $display("FAIL rand_c%0d got we=%b wr=%0d wd=%h rdy=%b haz=%b stall=%b busy=%h want we=%b wr=%0d wd=%h rdy=%b haz=%b stall=%b busy=%h",
                    c, rf_we_o, rf_wr_o, rf_wd_o, lu_ready_o, hazard_o, wb_stall_o, busy_o,
                    e_we, e_wr, e_wd, !full, e_haz, forced, m_busy);
            end
            tick();
            if (e_pop) begin
                if (q_rd[0] != 0) m_busy[q_rd[0]] = 1'b0;
                void'(q_rd.pop_front()); void'(q_wd.pop_front());
            end
            if (lu_valid_i && !full) begin q_rd.push_back(lu_rd_i); q_wd.push_back(lu_wd_i); end
            if (lu_issue_i && lu_issue_rd_i != 0) m_busy[lu_issue_rd_i] = 1'b1;
            if (e_pop) m_starve = 0;
            else if (m_armed && nonempty) m_starve++;
            m_armed = 1'b1;
        end
        idle(); tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_issue();
        test_backpressure();
        test_set_wins();
        test_starve();
        test_reset_mid();
        test_random(400);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
